pipe_dbg_ctrl: RTL and testbench
================================

Name: pipe_dbg_ctrl

Overview:
Run-control and debug sequencer for the 5-stage pipeline CPU. It gates pipeline advance through cpu_run and supports free-run, halt, N-cycle single-step and PC breakpoints. In the halted state it scans the register file through the CPU's reg_sel/reg_data debug port and streams the contents out over a valid/ready interface. It also keeps the advance-cycle counter that benches use for cycle-stamped logging.

Parameters:
NREG, 32, number of architectural registers dumped (indices 0..NREG-1, NREG ≤ 32)
CNT_W, 32, width of cycle_cnt and of the step counter
START_RUN, 1, state after reset: 1 = RUN, 0 = HALT

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge
cmd_op  in  2  00 RUN, 01 HALT, 10 STEP, 11 DUMP
cmd_arg  in  CNT_W  STEP cycle count; ignored for other ops
cmd_err  out  1  1-cycle pulse: accepted command was illegal in the current state
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
pc  in  32  CPU IF-stage PC
cpu_run  out  1  pipeline advance enable (CPU holds all state when 0)
reg_sel  out  5  register-file debug read select
reg_data  in  32  register-file debug read data (asynchronous read)
dump_valid  out  1  dump beat valid
dump_ready  in  1  dump beat consumed
dump_idx  out  5  register index of the current beat
dump_data  out  32  register value of the current beat
dump_done  out  1  1-cycle pulse after the last beat
halt_event  out  1  1-cycle pulse on entry to HALT from RUN or STEP
halt_cause  out  2  0 reset, 1 HALT cmd, 2 step done, 3 breakpoint
dbg_state  out  2  0 RUN, 1 HALT, 2 STEP, 3 DUMP
cycle_cnt  out  CNT_W  count of cycles with cpu_run=1

Behaviour:
- Reset (any cycle, including mid-STEP or mid-DUMP):
  - state = START_RUN ? RUN : HALT; step_cnt = 0; dump index = 0; cycle_cnt = 0; halt_cause = 0; bp-skip flag = 0.
  - All pulses low; dump_valid = 0.
- Combinational outputs:
  - cpu_run = (state == RUN) || (state == STEP).
  - cmd_ready = (state == RUN) || (state == HALT).
  - reg_sel = dump index while in DUMP, else 0.
- cycle_cnt increments on every posedge with cpu_run=1 and wraps modulo 2^CNT_W.
- Breakpoint hit (bp_hit) = cpu_run && bp_en && (pc == bp_addr) && !bp_skip.
  - The instruction at bp_addr is fetched on that edge.
  - The CPU is halted from the next cycle onward.
- bp_skip:
  - Set when leaving HALT via RUN or STEP.
  - Cleared after the first cpu_run=1 cycle, so resuming at a breakpoint PC does not re-trap.
- RUN state:
  - HALT cmd → HALT, cause 1.
  - RUN cmd → no-op.
  - STEP or DUMP cmd → consumed, cmd_err pulse, stay in RUN.
  - bp_hit → HALT, cause 3. If a HALT cmd arrives in the same cycle, the command is consumed and cause is 3.
- HALT state:
  - RUN cmd → RUN.
  - STEP cmd → STEP with step_cnt = (cmd_arg == 0) ? 1 : cmd_arg.
  - DUMP cmd → DUMP, index 0.
  - HALT cmd → no-op.
- STEP timing: if the command is accepted at edge k, cpu_run is high for cycles k+1 .. k+N.
  - step_cnt decrements on each cycle; on the decrement to 0, state → HALT with cause 2.
  - bp_hit during STEP → HALT, cause 3; this takes priority over step completion in the same cycle.
- DUMP state:
  - dump_valid = 1; dump_idx = index; dump_data = reg_data. Data is stable because cpu_run = 0.
  - On dump_valid && dump_ready, index increments.
  - The handshake at index NREG-1 → HALT, dump_done pulse, index reset to 0. halt_cause is unchanged and there is no halt_event.
  - Beats stall indefinitely while dump_ready = 0.
- halt_event and halt_cause update on the same edge the state enters HALT.

Test Plan:
- START_RUN=1, release reset, no commands for 20 cycles → cpu_run=1 throughout, cycle_cnt=20, dbg_state=0.
- In RUN: issue HALT → next cycle cpu_run=0, halt_event pulse, halt_cause=1. Then issue STEP with arg 3 → exactly 3 cpu_run cycles, then HALT with cause 2 and cycle_cnt advanced by 3. Repeat with arg 0 → exactly 1 cycle.
- bp_en=1, bp_addr=0x0000000C, PC sequence 0,4,8,C,10 → halt after the edge where pc=0x0C, cause 3. A following RUN must not re-trap at 0x0C; the next match does trap.
- Same-cycle HALT cmd and bp_hit → cause 3, single halt_event. In RUN, a DUMP cmd → cmd_err pulse and state stays RUN.
- In HALT, reg model x_i = 0x100+i: DUMP with dump_ready toggling 1/0 → 32 beats, idx 0..31, data 0x100..0x11F, no duplicate or skipped index, dump_done once, back in HALT.
- Assert rstn=0 mid-DUMP (index 7) and mid-STEP → next cycle all outputs at their reset values; dump restarts from index 0.

Source files
------------

// File: rtl/pipe_dbg_ctrl.sv
// Run-control and debug sequencer for the 5-stage pipeline: gates pipeline advance,
// handles halt/step/breakpoint, and streams a register-file dump over valid/ready.
module pipe_dbg_ctrl #(
    parameter int NREG      = 32,
    parameter int CNT_W     = 32,
    parameter bit START_RUN = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    output logic             cmd_err,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             cpu_run,
    output logic [4:0]       reg_sel,
    input  logic [31:0]      reg_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_idx,
    output logic [31:0]      dump_data,
    output logic             dump_done,
    output logic             halt_event,
    output logic [1:0]       halt_cause,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_STEP = 2'd2,
        S_DUMP = 2'd3
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    localparam logic [1:0] CAUSE_CMD  = 2'd1;
    localparam logic [1:0] CAUSE_STEP = 2'd2;
    localparam logic [1:0] CAUSE_BP   = 2'd3;

    localparam logic [4:0] LAST_IDX    = 5'(NREG - 1);
    localparam state_t     RESET_STATE = START_RUN ? S_RUN : S_HALT;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
    logic [4:0]       idx, idx_nxt;
    logic [1:0]       cause_nxt;
    logic             bp_skip, bp_skip_nxt;
    logic             err_nxt, done_nxt, hev_nxt;
    logic             cmd_acc, bp_hit;

    assign cpu_run    = (state == S_RUN) || (state == S_STEP);
    assign cmd_ready  = (state == S_RUN) || (state == S_HALT);
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign bp_hit     = cpu_run && bp_en && (pc == bp_addr) && !bp_skip;
    assign dump_valid = (state == S_DUMP);
    assign reg_sel    = (state == S_DUMP) ? idx : 5'd0;
    assign dump_idx   = idx;
    assign dump_data  = reg_data;
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= RESET_STATE;
            step_cnt   <= '0;
            idx        <= '0;
            halt_cause <= 2'd0;
            bp_skip    <= 1'b0;
            cmd_err    <= 1'b0;
            dump_done  <= 1'b0;
            halt_event <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            step_cnt   <= step_cnt_nxt;
            idx        <= idx_nxt;
            halt_cause <= cause_nxt;
            bp_skip    <= bp_skip_nxt;
            cmd_err    <= err_nxt;
            dump_done  <= done_nxt;
            halt_event <= hev_nxt;
            if (cpu_run)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        step_cnt_nxt = step_cnt;
        idx_nxt      = idx;
        cause_nxt    = halt_cause;
        // The skip only covers the first advancing cycle after a resume
        bp_skip_nxt  = cpu_run ? 1'b0 : bp_skip;
        err_nxt      = 1'b0;
        done_nxt     = 1'b0;
        hev_nxt      = 1'b0;
        case (state)
            S_RUN: begin
                if (cmd_acc && (cmd_op == OP_STEP || cmd_op == OP_DUMP))
                    err_nxt = 1'b1;
                if (bp_hit) begin
                    state_nxt = S_HALT;
                    cause_nxt = CAUSE_BP;
                    hev_nxt   = 1'b1;
                end else if (cmd_acc && cmd_op == OP_HALT) begin
                    state_nxt = S_HALT;
                    cause_nxt = CAUSE_CMD;
                    hev_nxt   = 1'b1;
                end
            end
            S_HALT: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_nxt   = S_RUN;
                            bp_skip_nxt = 1'b1;
                        end
                        OP_STEP: begin
                            state_nxt    = S_STEP;
                            step_cnt_nxt = (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
                            bp_skip_nxt  = 1'b1;
                        end
                        OP_DUMP: begin
                            state_nxt = S_DUMP;
                            idx_nxt   = 5'd0;
                        end
                        default: ;
                    endcase
                end
            end
            S_STEP: begin
                step_cnt_nxt = step_cnt - CNT_W'(1);
                if (bp_hit) begin
                    state_nxt = S_HALT;
                    cause_nxt = CAUSE_BP;
                    hev_nxt   = 1'b1;
                end else if (step_cnt == CNT_W'(1)) begin
                    state_nxt = S_HALT;
                    cause_nxt = CAUSE_STEP;
                    hev_nxt   = 1'b1;
                end
            end
            S_DUMP: begin
                // Dump return to HALT keeps the original halt cause and raises no halt_event
                if (dump_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_HALT;
                        idx_nxt   = 5'd0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipe_dbg_ctrl.sv
// Directed-plus-random bench for pipe_dbg_ctrl: step counts, breakpoint PC walks and
// register dumps are checked against expectations derived from the run-control rules.
module tb_pipe_dbg_ctrl;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        cmd_err;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_run;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_done;
    logic        halt_event;
    logic [1:0]  halt_cause;
    logic [1:0]  dbg_state;
    logic [31:0] cycle_cnt;

    logic [31:0] regs [32];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_cnt;

    assign reg_data = regs[reg_sel];

    pipe_dbg_ctrl #(.NREG(32), .CNT_W(32), .START_RUN(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .cmd_err(cmd_err),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_run(cpu_run),
        .reg_sel(reg_sel), .reg_data(reg_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .dump_done(dump_done),
        .halt_event(halt_event), .halt_cause(halt_cause), .dbg_state(dbg_state),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_arg   = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, dbg_state, 0);
        chk({tag, "_cpu_run"}, cpu_run, 1);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
        chk({tag, "_cause"}, halt_cause, 0);
        chk({tag, "_halt_event"}, halt_event, 0);
        chk({tag, "_cmd_err"}, cmd_err, 0);
        chk({tag, "_dump_valid"}, dump_valid, 0);
        chk({tag, "_dump_done"}, dump_done, 0);
        chk({tag, "_reg_sel"}, reg_sel, 0);
    endtask

    // Accepts a STEP from HALT and counts the advancing cycles until HALT is re-entered
    task automatic do_step(input logic [31:0] arg, input int n_exp);
        int runs = 0;
        int hev  = 0;
        bit halted = 0;
        cmd(OP_STEP, arg);
        chk("step_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < n_exp + 8; i++) begin
            if (dbg_state == 2'd1) begin
                halted = 1;
                break;
            end
            if (cpu_run) runs++;
            tick();
            if (halt_event) hev++;
        end
        chk("step_halted", halted, 1);
        chk("step_run_cycles", runs, n_exp);
        chk("step_halt_event", hev, 1);
        chk("step_cause", halt_cause, 2);
        exp_cnt += n_exp;
        chk("step_cycle_cnt", cycle_cnt, exp_cnt);
    endtask

    // Lets the pipeline run; the fake CPU's PC advances by 4 (mod 32) on every advancing edge
    task automatic run_until_halt(output int edges, output int hev);
        bit was;
        edges = 0;
        hev   = 0;
        for (int i = 0; i < 64; i++) begin
            if (dbg_state == 2'd1) break;
            was = cpu_run;
            tick();
            if (halt_event) hev++;
            if (was) begin
                pc = (pc + 32'd4) & 32'h1F;
                edges++;
            end
        end
    endtask

    task automatic do_dump(input bit rand_ready, input logic [1:0] cause_exp);
        logic [4:0]  qi [$];
        logic [31:0] qd [$];
        int dn = 0;
        int hev = 0;
        bit ph = 1'b1;
        cmd(OP_DUMP, 0);
        chk("dump_entry_valid", dump_valid, 1);
        chk("dump_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < 400; i++) begin
            if (dbg_state == 2'd1) break;
            dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : ph;
            ph = ~ph;
            if (dump_valid && dump_ready) begin
                qi.push_back(dump_idx);
                qd.push_back(dump_data);
            end
            tick();
            if (dump_done) dn++;
            if (halt_event) hev++;
        end
        dump_ready = 1'b0;
        chk("dump_beats", qi.size(), 32);
        for (int k = 0; k < qi.size(); k++) begin
            chk($sformatf("dump_idx_%0d", k), qi[k], k);
            chk($sformatf("dump_data_%0d", k), qd[k], regs[k]);
        end
        chk("dump_done_count", dn, 1);
        chk("dump_no_halt_event", hev, 0);
        chk("dump_back_halt", dbg_state, 1);
        chk("dump_cause_kept", halt_cause, cause_exp);
    endtask

    initial begin
        int edges, hev, bad, n;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0;
        bp_en = 1'b0; bp_addr = '0; pc = 32'h0; dump_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;

        repeat (3) tick();
        check_reset("rst0");

        // Free run after reset
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cpu_run || dbg_state != 2'd0) bad++;
            tick();
        end
        chk("freerun_bad_cycles", bad, 0);
        chk("freerun_cycle_cnt", cycle_cnt, 20);

        // HALT from RUN
        cmd(OP_HALT, 0);
        chk("halt_cpu_run", cpu_run, 0);
        chk("halt_event", halt_event, 1);
        chk("halt_cause", halt_cause, 1);
        chk("halt_state", dbg_state, 1);
        exp_cnt = 32'd21;
        chk("halt_cycle_cnt", cycle_cnt, exp_cnt);
        tick();
        chk("halt_event_pulse", halt_event, 0);

        do_step(32'd3, 3);
        do_step(32'd0, 1);
        n = $urandom_range(2, 12);
        do_step(32'(n), n);

        // Breakpoint at 0x0C, then resume from the breakpoint PC
        bp_en = 1'b1; bp_addr = 32'h0C; pc = 32'h0;
        cmd(OP_RUN, 0);
        run_until_halt(edges, hev);
        chk("bp1_edges", edges, 4);
        chk("bp1_halt_event", hev, 1);
        chk("bp1_cause", halt_cause, 3);
        exp_cnt += 4;
        chk("bp1_cycle_cnt", cycle_cnt, exp_cnt);
        pc = 32'h0C;
        cmd(OP_RUN, 0);
        run_until_halt(edges, hev);
        chk("bp2_edges", edges, 9);
        chk("bp2_cause", halt_cause, 3);
        exp_cnt += 9;
        chk("bp2_cycle_cnt", cycle_cnt, exp_cnt);

        // HALT command in the same cycle as a breakpoint hit
        pc = 32'h08;
        cmd(OP_RUN, 0);
        tick();
        pc = 32'h0C;
        cmd(OP_HALT, 0);
        chk("same_state", dbg_state, 1);
        chk("same_cause", halt_cause, 3);
        chk("same_halt_event", halt_event, 1);
        chk("same_cmd_err", cmd_err, 0);
        tick();
        chk("same_single_event", halt_event, 0);
        exp_cnt += 2;
        chk("same_cycle_cnt", cycle_cnt, exp_cnt);
        bp_en = 1'b0;

        // Illegal DUMP while running
        cmd(OP_RUN, 0);
        cmd(OP_DUMP, 0);
        chk("illegal_cmd_err", cmd_err, 1);
        chk("illegal_state", dbg_state, 0);
        chk("illegal_no_dump", dump_valid, 0);
        tick();
        chk("illegal_err_pulse", cmd_err, 0);
        cmd(OP_HALT, 0);
        chk("illegal_then_halt", dbg_state, 1);
        chk("illegal_then_cause", halt_cause, 1);

        do_dump(1'b0, 2'd1);
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        do_dump(1'b1, 2'd1);

        // Reset in the middle of a dump
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        cmd(OP_DUMP, 0);
        dump_ready = 1'b1;
        repeat (7) tick();
        dump_ready = 1'b0;
        chk("middump_idx", dump_idx, 7);
        chk("middump_reg_sel", reg_sel, 7);
        rstn = 1'b0;
        tick();
        check_reset("rst_dump");
        rstn = 1'b1;
        cmd(OP_HALT, 0);
        do_dump(1'b0, 2'd1);

        // Reset in the middle of a step
        cmd(OP_STEP, 32'd10);
        tick();
        chk("midstep_state", dbg_state, 2);
        rstn = 1'b0;
        tick();
        check_reset("rst_step");
        rstn = 1'b1;
        tick();
        chk("post_rst_cycle_cnt", cycle_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
